// File: rtl/nn_3.sv
// rtl/nn_3.sv - single-layer Q16.16 dot-product engine over an external 8Kx32 memory
// Optional feature: define NN_RELU_EN to let cfg bit 8 enable the ReLU activation.
module nn_3 (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        RW,
    input  logic [12:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        pushA,
    input  logic        firstA,
    input  logic        lastA,
    input  logic [31:0] dataA,
    output logic        stopA,
    output logic        pushB,
    output logic        firstB,
    output logic        lastB,
    output logic [31:0] dataB,
    input  logic        stopB,
    output logic [12:0] mwadr,
    output logic        mwrite,
    output logic [31:0] mwdata,
    output logic [12:0] mr0,
    output logic [12:0] mr1,
    input  logic [31:0] mrdata0,
    input  logic [31:0] mrdata1
);
    typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_OUT} state_t;

    state_t             state, state_nx;
    logic [6:0]         count, ni, cnt_new;
    logic [5:0]         j, i, no_m1, wr_idx;
    logic               drain_cnt, wr_ok;
    logic signed [31:0] op_a, op_b;
    logic signed [63:0] full_prod;
    logic [31:0]        prod, acc, acc_next, result;
    logic               v1, v2;
    logic               a_acc, b_acc, last_i, last_j;
`ifdef NN_RELU_EN
    logic               relu;
`endif

    assign stopA  = sel | (state != S_IDLE);
    assign a_acc  = pushA & ~stopA;
    assign b_acc  = pushB & ~stopB;
    assign last_i = ({1'b0, i} == ni - 7'd1);
    assign last_j = (j == no_m1);

    // Input word placement: restart on firstA or empty buffer, drop past 64 words.
    always_comb begin
        wr_ok   = 1'b1;
        wr_idx  = 6'd0;
        cnt_new = count;
        if (firstA || count == 7'd0) begin
            cnt_new = 7'd1;
        end else if (count < 7'd64) begin
            wr_idx  = count[5:0];
            cnt_new = count + 7'd1;
        end else begin
            wr_ok = 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (a_acc && lastA) state_nx = S_BIAS;
            S_BIAS:  state_nx = S_MAC;
            S_MAC:   if (last_i) state_nx = S_DRAIN;
            S_DRAIN: if (drain_cnt) state_nx = S_OUT;
            S_OUT:   if (b_acc) state_nx = last_j ? S_IDLE : S_BIAS;
            default: state_nx = S_IDLE;
        endcase
    end

    // mr0 carries the host address in IDLE and cfg (address 0) while in BIAS.
    always_comb begin
        mr0 = 13'h0000;
        mr1 = 13'h0000;
        case (state)
            S_IDLE: mr0 = addr;
            S_BIAS: mr1 = 13'h0040 + {7'b0, j};
            S_MAC: begin
                mr0 = 13'h1800 + {7'b0, i};
                mr1 = 13'h0100 + {1'b0, j, i};
            end
            default: ;
        endcase
    end

    assign full_prod = 64'(op_a) * 64'(op_b);
    assign acc_next  = (state == S_BIAS) ? mrdata1 : (v2 ? acc + prod : acc);
`ifdef NN_RELU_EN
    assign result = (relu && acc_next[31]) ? 32'h0 : acc_next;
`else
    assign result = acc_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            dout      <= '0;
            mwrite    <= 1'b0;
            mwadr     <= '0;
            mwdata    <= '0;
            pushB     <= 1'b0;
            firstB    <= 1'b0;
            lastB     <= 1'b0;
            dataB     <= '0;
            count     <= '0;
            ni        <= '0;
            j         <= '0;
            i         <= '0;
            no_m1     <= '0;
            drain_cnt <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            prod      <= '0;
            acc       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
`ifdef NN_RELU_EN
            relu      <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            mwrite <= 1'b0;
            if (state == S_IDLE && sel) begin
                if (RW) begin
                    mwrite <= 1'b1;
                    mwadr  <= addr;
                    mwdata <= din;
                end else begin
                    dout <= mrdata0;
                end
            end
            if (a_acc) begin
                if (wr_ok) begin
                    mwrite <= 1'b1;
                    mwadr  <= 13'h1800 + {7'b0, wr_idx};
                    mwdata <= dataA;
                end
                count <= lastA ? 7'd0 : cnt_new;
                if (lastA) begin
                    ni <= cnt_new;
                    j  <= '0;
                end
            end
            if (state == S_BIAS && j == 6'd0) begin
                no_m1 <= mrdata0[5:0];
`ifdef NN_RELU_EN
                relu  <= mrdata0[8];
`endif
            end
            // Two-stage multiplier: operand register, then product register.
            op_a      <= mrdata0;
            op_b      <= mrdata1;
            v1        <= (state == S_MAC);
            prod      <= 32'(full_prod >>> 16);
            v2        <= v1;
            acc       <= acc_next;
            i         <= (state == S_MAC) ? i + 6'd1 : 6'd0;
            drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
            if (state == S_DRAIN && drain_cnt) begin
                pushB  <= 1'b1;
                dataB  <= result;
                firstB <= (j == 6'd0);
                lastB  <= last_j;
            end
            if (state == S_OUT && b_acc) begin
                pushB <= 1'b0;
                j     <= j + 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_nn_3.sv
// tb/tb_nn_3.sv - scoreboard bench for nn_3 with an external memory model
module tb_nn_3;
    logic        clk = 1'b0, rst = 1'b1, sel = 1'b0, RW = 1'b0;
    logic [12:0] addr = '0;
    logic [31:0] din = '0, dataA = '0;
    logic        pushA = 1'b0, firstA = 1'b0, lastA = 1'b0, stopB = 1'b0;
    logic [31:0] dout, dataB, mwdata, mrdata0, mrdata1;
    logic        stopA, pushB, firstB, lastB, mwrite;
    logic [12:0] mwadr, mr0, mr1;

    nn_3 dut (
        .clk(clk), .rst(rst), .sel(sel), .RW(RW), .addr(addr), .din(din), .dout(dout),
        .pushA(pushA), .firstA(firstA), .lastA(lastA), .dataA(dataA), .stopA(stopA),
        .pushB(pushB), .firstB(firstB), .lastB(lastB), .dataB(dataB), .stopB(stopB),
        .mwadr(mwadr), .mwrite(mwrite), .mwdata(mwdata), .mr0(mr0), .mr1(mr1),
        .mrdata0(mrdata0), .mrdata1(mrdata1)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:8191];
    assign mrdata0 = mem[mr0];
    assign mrdata1 = mem[mr1];
    always @(posedge clk) if (mwrite) mem[mwadr] <= mwdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int stop_mode = 0;
    logic manual_stop = 1'b0;
    always begin
        @(posedge clk);
        #1;
        stopB = (stop_mode == 1) ? ($urandom_range(0, 2) == 0) : manual_stop;
    end

    typedef struct {
        logic [31:0] data;
        logic        first;
        logic        last;
        int          ni;
    } exp_t;
    exp_t q[$];

    int total = 0, bad = 0, bias_cyc = 0;
    bit relu_on;
    logic [31:0] m_cfg;
    logic [31:0] m_bias [64];
    logic [31:0] m_w [64][64];
    logic [31:0] vec [70];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        bit prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
                continue;
            end
            if (pushA && lastA && !stopA) bias_cyc = cyc + 1;
            if (pushB) begin
                if (q.size() == 0) begin
                    chk("unexpected_pushB", 32'd1, 32'd0);
                end else begin
                    if (!prev) chk("latency", 32'(cyc - bias_cyc), 32'(q[0].ni + 3));
                    chk("dataB", dataB, q[0].data);
                    chk("firstB", 32'(firstB), 32'(q[0].first));
                    chk("lastB", 32'(lastB), 32'(q[0].last));
                    chk("stopA_busy", 32'(stopA), 32'd1);
                    if (!stopB) begin
                        q.delete(0);
                        bias_cyc = cyc + 1;
                    end
                end
            end
            prev = pushB;
        end
    endtask

    task automatic host_write(input logic [12:0] a, input logic [31:0] d);
        sel = 1'b1; RW = 1'b1; addr = a; din = d;
        @(posedge clk); #1;
        sel = 1'b0; RW = 1'b0; addr = '0;
    endtask

    task automatic host_read(input logic [12:0] a, input logic [31:0] exp);
        @(posedge clk); #1;
        sel = 1'b1; RW = 1'b0; addr = a;
        @(posedge clk); #1;
        sel = 1'b0; addr = '0;
        chk("host_read", dout, exp);
    endtask

    task automatic load_model(input int no, input int ni);
        host_write(13'h0000, m_cfg);
        for (int j = 0; j < no; j++) begin
            host_write(13'(32'h40 + j), m_bias[j]);
            for (int i = 0; i < ni; i++) host_write(13'(32'h100 + 64 * j + i), m_w[j][i]);
        end
    endtask

    task automatic randomize_model(input int no, input int n, input logic [31:0] cfgv);
        m_cfg = cfgv;
        for (int j = 0; j < no; j++) begin
            m_bias[j] = $urandom;
            for (int i = 0; i < 64; i++) m_w[j][i] = $urandom;
        end
        for (int k = 0; k < n; k++) vec[k] = $urandom;
    endtask

    task automatic expect_results(input int no, input int ni);
        for (int j = 0; j < no; j++) begin
            exp_t e;
            logic [31:0] a;
            a = m_bias[j];
            for (int i = 0; i < ni; i++) begin
                longint p;
                p = longint'($signed(m_w[j][i])) * longint'($signed(vec[i]));
                a = a + p[47:16];
            end
            if (relu_on && m_cfg[8] && a[31]) a = 32'h0;
            e.data = a; e.first = (j == 0); e.last = (j == no - 1); e.ni = ni;
            q.push_back(e);
        end
    endtask

    task automatic send_vec(input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            while (gaps && $urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
            pushA = 1'b1; firstA = (k == 0); lastA = (k == n - 1); dataA = vec[k];
            @(posedge clk); #1;
            pushA = 1'b0; firstA = 1'b0; lastA = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        chk("stopA_idle", 32'(stopA), 32'd0);
    endtask

    task automatic run_case(input int no, input int n, input bit gaps);
        load_model(no, (n > 64) ? 64 : n);
        expect_results(no, (n > 64) ? 64 : n);
        send_vec(n, gaps);
        wait_drain();
    endtask

    initial begin
`ifdef NN_RELU_EN
        relu_on = 1'b1;
`else
        relu_on = 1'b0;
`endif
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_stopA", 32'(stopA), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_pushB", 32'(pushB), 32'd0);
        chk("rst_flags", {30'd0, firstB, lastB}, 32'd0);
        chk("rst_dataB", dataB, 32'd0);
        chk("rst_mwrite", 32'(mwrite), 32'd0);
        chk("rst_mwadr", 32'(mwadr), 32'd0);
        chk("rst_mwdata", mwdata, 32'd0);
        chk("rst_mr", {3'd0, mr0, 3'd0, mr1}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        host_write(13'h0005, 32'hDEADBEEF);
        chk("hw_mwrite", 32'(mwrite), 32'd1);
        chk("hw_mwadr", 32'(mwadr), 32'h0005);
        chk("hw_mwdata", mwdata, 32'hDEADBEEF);
        host_read(13'h0005, 32'hDEADBEEF);

        // Directed dot product: 0.5 + 2*1 + 1*3 = 5.5
        m_cfg = 32'h0; m_bias[0] = 32'h00008000;
        m_w[0][0] = 32'h00020000; m_w[0][1] = 32'h00010000;
        vec[0] = 32'h00010000; vec[1] = 32'h00030000;
        run_case(1, 2, 1'b0);

        // ReLU on a negative result
        m_cfg = 32'h100; m_bias[0] = 32'h0; m_w[0][0] = 32'hFFFF0000;
        vec[0] = 32'h00010000;
        run_case(1, 1, 1'b0);

        // Back-pressure: hold the first result for 10 cycles
        randomize_model(3, 3, 32'h2);
        load_model(3, 3);
        expect_results(3, 3);
        stop_mode = 0; manual_stop = 1'b1;
        send_vec(3, 1'b0);
        for (int t = 0; t < 200 && !pushB; t++) begin
            @(posedge clk); #1;
        end
        chk("bp_pushB_seen", 32'(pushB), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        manual_stop = 1'b0;
        wait_drain();

        // Overlength vector: only the first 64 words count
        randomize_model(2, 70, 32'h1);
        load_model(2, 64);
        expect_results(2, 64);
        send_vec(70, 1'b0);
        chk("over_stopA", 32'(stopA), 32'd1);
        wait_drain();

        // Reset mid-compute discards the vector
        randomize_model(1, 8, 32'h0);
        load_model(1, 8);
        send_vec(8, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_pushB", 32'(pushB), 32'd0);
        chk("abort_stopA", 32'(stopA), 32'd0);

        // Randomized vectors with random stalls and input gaps
        stop_mode = 1;
        for (int c = 0; c < 8; c++) begin
            int no, n;
            no = $urandom_range(1, 4);
            n  = $urandom_range(1, 8);
            randomize_model(no, n, {23'd0, 1'($urandom_range(0, 1)), 2'd0, 6'(no - 1)});
            run_case(no, n, 1'b1);
        end
        stop_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nn_3.md
# nn_3

Single-layer fixed-point neural-network engine. An input vector arrives on stream A. The block stores it in an external 8K×32 memory that also holds the configuration, biases and weights. It computes one dot product per output neuron using a 2-stage pipelined signed multiplier and streams the results on stream B. A host register port reads and writes the same memory.

## Interface
- No parameters.
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- sel, RW  in  1,1  host access strobe; RW=1 write, RW=0 read.
- addr  in  13  host word address.
- din  in  32  host write data.
- dout  out  32  host read data.
- pushA, firstA, lastA  in  1 each  input-stream valid, first word, last word.
- dataA  in  32  input word, Q16.16 signed.
- stopA  out  1  input back-pressure.
- pushB, firstB, lastB  out  1 each  output-stream valid, first result, last result.
- dataB  out  32  result, Q16.16 signed.
- stopB  in  1  output back-pressure.
- mwadr  out  13  memory write address.
- mwrite  out  1  memory write enable.
- mwdata  out  32  memory write data.
- mr0, mr1  out  13  asynchronous read addresses.
- mrdata0, mrdata1  in  32  read data, combinational from mr0/mr1.

## Operation
- Memory map:
  - 0x0000 cfg: bits[5:0] = NO−1, giving 1..64 outputs; bit 8 = ReLU.
  - 0x0040+j: bias j.
  - 0x0100+64·j+i: weight (j,i).
  - 0x1800+i: input i.
- Host write (sel=1, RW=1): drives mwrite/mwadr/mwdata registered, next cycle.
- Host read (sel=1, RW=0): mr0=addr; dout=mrdata0 registered next cycle.
- Host accesses are legal only in IDLE.
- stopA = sel OR (state≠IDLE). It is combinational from sel.
- IDLE, receiving input:
  - An accepted word (pushA & !stopA) with firstA, or with count=0, is written to 0x1800 and sets count=1.
  - Otherwise the word goes to 0x1800+count and count++.
  - Words beyond 64 are dropped and count saturates at 64.
  - If lastA is set, NI=count and the block moves to BIAS next cycle.
- States: IDLE → BIAS → MAC → DRAIN → OUT → (BIAS for the next j, or IDLE after the last).
  - BIAS (1 cycle): mr1=0x0040+j; acc←bias.
  - MAC (NI cycles): mr0=0x1800+i, mr1=weight(j,i) into the multiplier.
  - DRAIN (2 cycles): flush the pipeline.
- Arithmetic:
  - 64-bit signed product; bits [47:16] are added to acc.
  - 32-bit wrap-around, no saturation.
- Activation: if ReLU is active and acc[31]=1, the result is 0.
- OUT:
  - dataB=result, pushB=1.
  - firstB=(j==0), lastB=(j==NO−1).
  - Outputs are held until a cycle with pushB & !stopB.
- cfg is sampled on entry to BIAS for j=0.

## Timing
- Reset values: all outputs 0, including stopA and dout; state IDLE; count 0.
- Memory writes land one cycle after acceptance.
- Per neuron: pushB rises NI+3 cycles after BIAS entry.
- First BIAS is the cycle after the lastA acceptance.
- Next BIAS is the cycle after B acceptance.
- pushB/dataB/firstB/lastB are registered and stable for the whole stall.
- rst mid-compute aborts to IDLE; the vector is discarded.

## Configuration
- NN_RELU_EN defined: cfg bit 8 enables ReLU.
- NN_RELU_EN undefined: bit 8 is ignored; activation is identity.

## Test plan
- Reset 3 cycles → all outputs 0 and stopA=0 after reset.
- Host write addr 0x0005, din 0xDEADBEEF → next cycle mwrite=1, mwadr=0x0005, mwdata=0xDEADBEEF. A read of 0x0005 returns dout=0xDEADBEEF.
- Dot product:
  - Setup: cfg=0, bias0=0x00008000, w(0,0)=0x00020000, w(0,1)=0x00010000.
  - Inputs: 0x00010000 (firstA), 0x00030000 (lastA).
  - Expected: dataB=0x00058000, firstB=lastB=1, pushB NI+3=5 cycles after BIAS entry.
- ReLU:
  - Setup: cfg=0x100, bias0=0, w(0,0)=0xFFFF0000.
  - Input: 0x00010000 (first+last).
  - Expected: dataB=0 with NN_RELU_EN, 0xFFFF0000 without.
- Back-pressure:
  - Setup: cfg=2 (3 outputs), stopB=1 for 10 cycles at the first pushB.
  - Expected: dataB stable throughout; results appear in order with flags 1/0, 0/0, 0/1; stopA=1 until return to IDLE.
- Overlength: 70 input words → only the first 64 are used, and stopA=1 from BIAS onward.
